// File: rtl/mux_scan_pkg.sv
// Shared widths and FSM state codes for the mux scan sequencer.
// Pure declarations: no logic, no latency, no flow control.
package mux_scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/next_chan_find.sv
// Finds the lowest enabled channel above cur (or at/above cur when from_start).
// Purely combinational: zero latency, no flow control.
module next_chan_find
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             from_start,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  // Walk downward so the lowest qualifying index is the one left standing.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && ((SEL_W'(i) > cur) || (from_start && (SEL_W'(i) == cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 8:1 mux selects over enabled channels, samples y after SETTLE_CYC cycles each.
// Word valid popcount(mask)*SETTLE_CYC edges after start; held in DONE until data_ready.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYC = 1
)
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [NCH-1:0] chan_mask,
  input  logic           y,
  output logic           s2,
  output logic           s1,
  output logic           s0,
  output logic           busy,
  output logic [NCH-1:0] data_out,
  output logic           data_valid,
  input  logic           data_ready
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  logic [NCH-1:0]   mask_r;
  logic [NCH-1:0]   shadow;
  logic [NCH-1:0]   merged;
  logic             in_idle;
  logic [NCH-1:0]   find_mask;
  logic [SEL_W-1:0] find_cur;
  logic [SEL_W-1:0] nxt;
  logic             found;

  assign in_idle = (state == IDLE);

  // In IDLE the finder looks at the live mask from index 0 inclusive; during
  // a scan it searches the captured mask strictly above the current channel.
  assign find_mask = in_idle ? chan_mask : mask_r;
  assign find_cur  = in_idle ? '0 : sel;

  next_chan_find u_find (
    .mask       (find_mask),
    .cur        (find_cur),
    .from_start (in_idle),
    .nxt        (nxt),
    .found      (found)
  );

  always_comb begin
    merged      = shadow;
    merged[sel] = y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      cnt        <= '0;
      mask_r     <= '0;
      shadow     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= '0;
          if (start) begin
            mask_r <= chan_mask;
            shadow <= '0;
            if (!found) begin
              data_out   <= '0;
              data_valid <= 1'b1;
              state      <= DONE;
            end else begin
              sel   <= nxt;
              cnt   <= CNT_RELOAD;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shadow <= merged;
            if (found) begin
              sel <= nxt;
              cnt <= CNT_RELOAD;
            end else begin
              data_out   <= merged;
              data_valid <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            sel        <= '0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

  assign {s2, s1, s0} = sel;
  assign busy         = !in_idle;

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the team's 8:1 data-flow multiplexer.
- Drives the mux select lines s2/s1/s0 through the enabled channels, waits a programmable settle time on each, and samples the mux output y.
- Assembles the samples into an 8-bit word and hands it downstream on a valid/ready handshake.
- Sits between the control logic, which issues start, and the consumer of the sampled word.

Parameters:
- SETTLE_CYC, 1, cycles each select value is held before y is sampled; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; accepted only in IDLE.
- chan_mask  input  8  channel enables, bit i = channel i; captured when start is accepted.
- y  input  1  output of the downstream 8:1 mux.
- s2  output  1  select MSB to mux.
- s1  output  1  select middle bit to mux.
- s0  output  1  select LSB to mux.
- busy  output  1  high while in SCAN or DONE.
- data_out  output  8  assembled sample word; bit i = y sampled with select = i.
- data_valid  output  1  data_out is valid.
- data_ready  input  1  consumer accepts data_out.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset, asserted at any time including mid-scan: immediately sets state=IDLE; {s2,s1,s0}=000; busy=0; data_out=0; data_valid=0; internal mask, shadow word and counter=0. No partial word is ever presented.
- States: IDLE, SCAN, DONE (3-state encoded FSM).
- IDLE:
  - Selects held at 000; busy=0; data_valid=0.
  - On an edge with start=1:
    - mask_r <= chan_mask.
    - shadow <= 0.
    - If chan_mask==0: go directly to DONE with data_out=0 and data_valid=1 on that edge.
    - Otherwise: sel <= lowest set bit index of chan_mask; cnt <= SETTLE_CYC-1; state <= SCAN.
- SCAN, evaluated each edge:
  - If cnt!=0: cnt <= cnt-1; sel unchanged.
  - If cnt==0: shadow[sel] <= y.
    - If a higher-indexed enabled channel exists in mask_r: sel <= next set bit above sel; cnt <= SETTLE_CYC-1.
    - Else: data_out <= shadow with the new bit merged; data_valid <= 1; state <= DONE.
- Latency: data_valid rises exactly N*SETTLE_CYC edges after the start-accept edge, where N = popcount(mask) ≥ 1.
- Masked-off channels are never selected and read as 0 in data_out.
- DONE:
  - data_out and data_valid held stable until data_ready=1.
  - On an edge with data_valid & data_ready: data_valid <= 0; state <= IDLE; selects <= 000.
  - data_out keeps its last value after the handshake (not cleared).
  - data_ready may already be high when data_valid rises; the handshake then completes on the next edge.
- start is ignored while busy=1. Minimum one IDLE cycle between scans.
- chan_mask changes after the accept edge have no effect on the scan in progress.
- Select outputs are registered; no combinational path from any input to s2/s1/s0.
- busy = (state != IDLE), registered-equivalent.
- y is assumed already synchronous to clk; no synchronizer inside this block.

Decomposition:
- Shared package mux_scan_pkg:
  - state typedef {IDLE, SCAN, DONE}.
  - constants NCH=8, SEL_W=3, CNT_W=4.
- One combinational sub-module, next_chan_find: inputs mask[7:0], cur[2:0]; outputs nxt[2:0] (lowest set bit with index > cur) and found.
  - Also used at start with an "include cur=0" variant, selected by an input flag from_start.

Test Plan:
- Reset mid-scan: mask=FF, SETTLE_CYC=1, y=1, assert rst_n=0 three cycles after start -> selects=000, data_valid=0, busy=0 immediately, without waiting for a clock edge.
- Full scan: mask=FF, SETTLE_CYC=1, y driven from a model 8:1 mux with d=8'hA5 -> selects step 0..7 on consecutive cycles; data_valid rises 8 edges after start accept; data_out=A5.
- Sparse mask with settle: mask=8'b1000_0101, SETTLE_CYC=3, d=8'hFF -> select sequence 0,2,7, each held 3 cycles; data_valid at edge 9; data_out=8'h85.
- Zero mask: mask=00, start=1 -> data_valid=1 on the accept edge with data_out=00; no select change.
- Backpressure: complete a scan with data_ready=0 for 5 cycles, toggle d and pulse start meanwhile -> data_out unchanged, busy=1, start ignored; data_ready=1 -> IDLE on the next edge.
- Back-to-back scans: handshake, then start on the next IDLE cycle with mask=0F and d=8'h3C -> second word = 8'h0C; first word not corrupted before its handshake.
